// File: rtl/ecc_arbiter.sv
// Shares one ECC point-multiplier core between two requesters using round-robin arbitration.
// It holds the core's start level for the whole operation, captures each result, and aborts on a hung core.
module ecc_arbiter #(
  parameter int unsigned WIDTH   = 164,
  parameter int unsigned TO_BITS = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             estart,
  input  logic             edone,
  input  logic [WIDTH-1:0] Pox,
  input  logic [WIDTH-1:0] Poy,
  output logic [WIDTH-1:0] res0_x,
  output logic [WIDTH-1:0] res0_y,
  output logic [WIDTH-1:0] res1_x,
  output logic [WIDTH-1:0] res1_y,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  localparam logic [TO_BITS-1:0] WDOG_MAX = '1;

  logic [1:0]         state, state_nx;
  logic               owner, owner_nx;
  logic               last, last_nx;
  logic [TO_BITS-1:0] wdog, wdog_nx;
  logic               estart_nx, gnt0_nx, gnt1_nx;
  logic               done0_nx, done1_nx, err0_nx, err1_nx;
  logic               capture_c;

  // Next-state, ownership and watchdog logic; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    last_nx   = last;
    wdog_nx   = wdog;
    capture_c = 1'b0;

    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nx = RUN;
          owner_nx = ~last;
          wdog_nx  = '0;
        end else if (req0) begin
          state_nx = RUN;
          owner_nx = 1'b0;
          wdog_nx  = '0;
        end else if (req1) begin
          state_nx = RUN;
          owner_nx = 1'b1;
          wdog_nx  = '0;
        end
      end
      RUN: begin
        // A completion on the terminal watchdog cycle still counts as success
        if (edone) begin
          state_nx  = DONE;
          last_nx   = owner;
          capture_c = 1'b1;
        end else if (wdog == WDOG_MAX) begin
          state_nx = ABORT;
          last_nx  = owner;
        end else begin
          wdog_nx = TO_BITS'(wdog + 1'b1);
        end
      end
      DONE:    state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    estart_nx = (state_nx == RUN);
    gnt0_nx   = (state_nx == RUN)   && !owner_nx;
    gnt1_nx   = (state_nx == RUN)   &&  owner_nx;
    done0_nx  = (state_nx == DONE)  && !owner_nx;
    done1_nx  = (state_nx == DONE)  &&  owner_nx;
    err0_nx   = (state_nx == ABORT) && !owner_nx;
    err1_nx   = (state_nx == ABORT) &&  owner_nx;
  end

  // State and output registers; last resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      wdog   <= '0;
      estart <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last   <= last_nx;
      wdog   <= wdog_nx;
      estart <= estart_nx;
      gnt0   <= gnt0_nx;
      gnt1   <= gnt1_nx;
      done0  <= done0_nx;
      done1  <= done1_nx;
      err0   <= err0_nx;
      err1   <= err1_nx;
    end
  end

  // Result registers update only on the edge that enters DONE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      res0_x <= '0;
      res0_y <= '0;
      res1_x <= '0;
      res1_y <= '0;
    end else if (capture_c) begin
      if (owner) begin
        res1_x <= Pox;
        res1_y <= Poy;
      end else begin
        res0_x <= Pox;
        res0_y <= Poy;
      end
    end
  end

endmodule

// File: tb/tb_ecc_arbiter.sv
// Scoreboard bench for ecc_arbiter with a 4-bit watchdog: the stimulus pushes expected completions
// and a negedge monitor checks every done/err pulse, run length, grant ownership and invariants.
module tb_ecc_arbiter;

  localparam int unsigned W      = 164;
  localparam int unsigned TOB    = 4;
  localparam int          WD_CYC = 16;

  logic          clk;
  logic          n_rst;
  logic          req0, req1, gnt0, gnt1, estart, edone;
  logic [W-1:0]  Pox, Poy;
  logic [W-1:0]  res0_x, res0_y, res1_x, res1_y;
  logic          done0, done1, err0, err1;
  logic [W-1:0]  garb;

  typedef struct {
    int           port;
    bit           err;
    int           run_len;
    logic [W-1:0] r0x, r0y, r1x, r1y;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mx[2];
  logic [W-1:0] my[2];
  int           errors = 0;
  int           checks = 0;
  int           cyc;

  ecc_arbiter #(.WIDTH(W), .TO_BITS(TOB)) dut (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .estart(estart), .edone(edone), .Pox(Pox), .Poy(Poy),
    .res0_x(res0_x), .res0_y(res0_y), .res1_x(res1_x), .res1_y(res1_y),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for estart with a cycle budget; returns the number of edges waited
  task automatic wait_start(output int n);
    n = 0;
    while (!estart && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!estart) chk("start_timeout", W'(estart), W'(1));
  endtask

  // Called in RUN cycle 1: records the expectation, then plays the core (lat=0 means never answer)
  task automatic finish_op(input int port, input int lat, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int drop_at);
    exp_t e;
    e.port    = port;
    e.err     = (lat == 0);
    e.run_len = (lat == 0) ? WD_CYC : lat;
    if (lat != 0) begin
      mx[port] = x;
      my[port] = y;
    end
    e.r0x = mx[0]; e.r0y = my[0]; e.r1x = mx[1]; e.r1y = my[1];
    sb.push_back(e);
    for (int c = 1; c <= WD_CYC + 4; c++) begin
      if (c == drop_at) begin
        if (port == 0) req0 = 1'b0;
        else req1 = 1'b0;
      end
      if (c == lat) begin
        edone = 1'b1;
        Pox   = x;
        Poy   = y;
      end
      @(posedge clk); #1;
      edone = 1'b0;
      Pox   = garb;
      Poy   = garb;
      if (!estart) break;
    end
    chk("op_end_estart", W'(estart), W'(0));
  endtask

  task automatic clear_model();
    mx[0] = '0; my[0] = '0; mx[1] = '0; my[1] = '0;
  endtask

  // Monitor: pops the scoreboard on every done/err pulse and checks invariants each cycle
  int  run_len = 0;
  int  low_len = 99;
  bit  prev_pulse = 1'b0;
  bit  gnt_bad = 1'b0;
  initial begin
    exp_t e;
    bit   pulse, bad;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        run_len = 0; low_len = 99; prev_pulse = 1'b0; gnt_bad = 1'b0;
        continue;
      end
      pulse = done0 | done1 | err0 | err1;
      bad = (gnt0 && gnt1) || ((done0 || done1) && (err0 || err1)) || (done0 && done1) ||
            (err0 && err1) || (pulse && prev_pulse) || ((gnt0 || gnt1) != estart);
      chk("invariants", W'(bad), W'(0));
      if (estart) begin
        if (run_len == 0) chk("start_gap_ge2", W'(low_len >= 2), W'(1));
        run_len++;
        low_len = 0;
        if (sb.size() > 0)
          if (gnt0 != (sb[0].port == 0) || gnt1 != (sb[0].port == 1)) gnt_bad = 1'b1;
      end else begin
        low_len++;
      end
      if (pulse) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done0=%b done1=%b err0=%b err1=%b required none",
                   done0, done1, err0, err1);
        end else begin
          e = sb.pop_front();
          chk("pulse_port", W'(done1 | err1), W'(e.port));
          chk("pulse_is_err", W'(err0 | err1), W'(e.err));
          chk("run_len", W'(run_len), W'(e.run_len));
          chk("gnt_owner", W'(gnt_bad), W'(0));
          chk("res0_x", res0_x, e.r0x);
          chk("res0_y", res0_y, e.r0y);
          chk("res1_x", res1_x, e.r1x);
          chk("res1_y", res1_y, e.r1y);
        end
        run_len = 0;
        gnt_bad = 1'b0;
      end
      prev_pulse = pulse;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    garb  = {41{4'hB}};
    n_rst = 1'b0; req0 = 1'b0; req1 = 1'b0; edone = 1'b0; Pox = garb; Poy = garb;
    clear_model();
    repeat (2) @(posedge clk); #1;
    chk("rst_estart", W'(estart), W'(0));
    chk("rst_gnt", W'({gnt0, gnt1}), W'(0));
    chk("rst_pulses", W'({done0, done1, err0, err1}), W'(0));
    chk("rst_res0_x", res0_x, '0);
    chk("rst_res1_y", res1_y, '0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // edone while idle must be ignored
    edone = 1'b1; Pox = W'(1); Poy = W'(2);
    @(posedge clk); #1;
    edone = 1'b0; Pox = garb; Poy = garb;
    chk("idle_edone_estart", W'(estart), W'(0));
    chk("idle_edone_res0", res0_x, '0);

    // single request, core answers in RUN cycle 8
    req0 = 1'b1;
    wait_start(cyc);
    chk("start_latency", W'(cyc), W'(1));
    finish_op(0, 8, 164'h1234, 164'h5678, 0);
    req0 = 1'b0;
    repeat (3) @(posedge clk); #1;

    // reset while idle clears results, then a tie alternates 0,1,0,1
    n_rst = 1'b0; #1;
    chk("rst_clears_res0_x", res0_x, '0);
    clear_model();
    @(posedge clk); #1;
    n_rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(cyc);
      finish_op(i % 2, 3 + i, W'(32'hA000 + i), W'(32'hB000 + i), 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk); #1;

    // watchdog abort on port 1 leaves res1 unchanged
    req1 = 1'b1;
    wait_start(cyc);
    finish_op(1, 0, '0, '0, 0);
    req1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // edone on the terminal watchdog cycle wins
    req0 = 1'b1;
    wait_start(cyc);
    finish_op(0, WD_CYC, 164'hC0FFEE, 164'hBEEF, 0);
    req0 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // owner drops req mid-run; queued port 1 granted two cycles after DONE
    req0 = 1'b1;
    wait_start(cyc);
    req1 = 1'b1;
    finish_op(0, 6, 164'h7777, 164'h8888, 3);
    wait_start(cyc);
    chk("queued_grant_delay", W'(cyc), W'(2));
    finish_op(1, 4, 164'h9999, 164'hAAAA, 0);
    req1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // port 0 served last so a tie would now favour port 1 unless reset intervenes
    req0 = 1'b1;
    wait_start(cyc);
    finish_op(0, 2, 164'h1111, 164'h2222, 0);
    req0 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // reset in the middle of a port 1 operation
    req1 = 1'b1;
    wait_start(cyc);
    repeat (3) @(posedge clk); #1;
    n_rst = 1'b0; #1;
    chk("midrun_rst_estart", W'(estart), W'(0));
    chk("midrun_rst_gnt", W'({gnt0, gnt1}), W'(0));
    chk("midrun_rst_res0_x", res0_x, '0);
    chk("midrun_rst_res1_x", res1_x, '0);
    clear_model();
    req0 = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b1;
    wait_start(cyc);
    finish_op(0, 5, 164'h3333, 164'h4444, 0);
    req0 = 1'b0;
    wait_start(cyc);
    finish_op(1, 3, 164'h5555, 164'h6666, 0);
    req1 = 1'b0;

    repeat (6) @(posedge clk); #1;
    chk("scoreboard_drained", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
